// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: byte-FSM states, data width and counter-width helper shared by the word receiver
package uart_rx_pkg;
    localparam int DATA_BITS = 8;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: rx synchronizer and single-frame receiver; UART_RX_PARITY_EN adds an even-parity bit
module uart_rx_byte
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 byte_valid,
    output logic                 frame_err,
    output logic                 active
);
    localparam int CW = cnt_w(CLKS_PER_BIT);
    localparam int BC = cnt_w(DATA_BITS);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    state_t state;
    logic rx_m, rx_s, wait_high, tick;
    logic [CW-1:0] cnt;
    logic [BC-1:0] bit_cnt;
    logic [DATA_BITS-1:0] sh;
    assign tick = cnt == '0;
    assign active = state != IDLE;
    // wait_high blocks new start bits until the line has been seen idle after reset or a bad frame
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_m       <= 1'b1;
            rx_s       <= 1'b1;
            state      <= IDLE;
            wait_high  <= 1'b1;
            cnt        <= '0;
            bit_cnt    <= '0;
            sh         <= '0;
            data       <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_m       <= rx;
            rx_s       <= rx_m;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            cnt        <= tick ? FULL : cnt - CW'(1);
            case (state)
                IDLE: begin
                    cnt     <= HALF;
                    bit_cnt <= '0;
                    if (rx_s) wait_high <= 1'b0;
                    else if (!wait_high) state <= START;
                end
                START: if (tick) state <= rx_s ? IDLE : DATA;
                DATA: if (tick) begin
                    sh      <= {rx_s, sh[DATA_BITS-1:1]};
                    bit_cnt <= bit_cnt + BC'(1);
                    if (bit_cnt == BC'(DATA_BITS - 1))
`ifdef UART_RX_PARITY_EN
                        state <= PARITY;
`else
                        state <= STOP;
`endif
                end
`ifdef UART_RX_PARITY_EN
                PARITY: if (tick) begin
                    state <= ^{sh, rx_s} ? IDLE : STOP;
                    if (^{sh, rx_s}) begin
                        frame_err <= 1'b1;
                        wait_high <= 1'b1;
                    end
                end
`endif
                STOP: if (tick) begin
                    state      <= IDLE;
                    byte_valid <= rx_s;
                    frame_err  <= !rx_s;
                    wait_high  <= !rx_s;
                    if (rx_s) data <= sh;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: rtl/uart_word_rx.sv
// uart_word_rx: assembles LSB-first UART bytes into words with valid/ready handoff, overrun and timeout
// UART_RX_PARITY_EN selects 8-E-1 framing in the byte receiver
module uart_word_rx
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT   = 434,
    parameter int BYTES_PER_WORD = 8,
    parameter int TIMEOUT_BITS   = 40
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        rx,
    output logic [8*BYTES_PER_WORD-1:0] word_out,
    output logic                        word_valid,
    input  logic                        word_ready,
    output logic                        frame_err,
    output logic                        timeout_err,
    output logic                        overrun,
    output logic                        busy
);
    localparam int WW = DATA_BITS * BYTES_PER_WORD;
    localparam int IW = cnt_w(BYTES_PER_WORD);
    localparam int TW = cnt_w(TIMEOUT_BITS * CLKS_PER_BIT);
    localparam logic [IW-1:0] LAST = IW'(BYTES_PER_WORD - 1);
    localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_BITS * CLKS_PER_BIT - 1);
    logic [DATA_BITS-1:0] data;
    logic byte_valid, active, last;
    logic [IW-1:0] byte_idx;
    logic [WW-1:0] partial, full;
    logic [TW-1:0] tcnt;
    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte (
        .clk(clk),
        .reset(reset),
        .rx(rx),
        .data(data),
        .byte_valid(byte_valid),
        .frame_err(frame_err),
        .active(active)
    );
    assign last = byte_idx == LAST;
    assign busy = active | byte_valid | (byte_idx != '0);
    always_comb begin
        full = partial;
        full[byte_idx*DATA_BITS +: DATA_BITS] = data;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            byte_idx    <= '0;
            partial     <= '0;
            tcnt        <= '0;
            word_out    <= '0;
            word_valid  <= 1'b0;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
            tcnt        <= (active || byte_idx == '0) ? '0 : tcnt + TW'(1);
            if (word_valid && word_ready) word_valid <= 1'b0;
            if (frame_err) begin
                byte_idx <= '0;
                partial  <= '0;
            end else if (byte_valid) begin
                byte_idx <= last ? '0 : byte_idx + IW'(1);
                partial  <= last ? '0 : full;
                // a word completing in the accept cycle replaces the consumed one
                if (last && (!word_valid || word_ready)) begin
                    word_out   <= full;
                    word_valid <= 1'b1;
                end
                overrun <= last && word_valid && !word_ready;
            end else if (tcnt == TLIM) begin
                timeout_err <= 1'b1;
                byte_idx    <= '0;
                partial     <= '0;
                tcnt        <= '0;
            end
        end
    end
endmodule

// File: tb/tb_uart_word_rx.sv
// tb_uart_word_rx: random-data bench with a word-queue reference model; define UART_RX_PARITY_EN for 8-E-1
module tb_uart_word_rx;
    localparam int CPB = 16;
    localparam int BPW = 8;
    localparam int TOB = 40;
    logic clk = 1'b0, reset = 1'b1, rx = 1'b1, word_ready = 1'b1;
    logic [63:0] word_out;
    logic word_valid, frame_err, timeout_err, overrun, busy;
    int n_chk = 0, n_fail = 0;
    int n_fe = 0, n_to = 0, n_ov = 0, n_rise = 0;
    logic wv_q = 1'b0;
    logic [63:0] got[$];
    logic [63:0] exp_q[$];
    uart_word_rx #(.CLKS_PER_BIT(CPB), .BYTES_PER_WORD(BPW), .TIMEOUT_BITS(TOB)) dut (
        .clk(clk),
        .reset(reset),
        .rx(rx),
        .word_out(word_out),
        .word_valid(word_valid),
        .word_ready(word_ready),
        .frame_err(frame_err),
        .timeout_err(timeout_err),
        .overrun(overrun),
        .busy(busy)
    );
    always #5 clk = ~clk;
    always @(negedge clk) begin
        if (frame_err) n_fe <= n_fe + 1;
        if (timeout_err) n_to <= n_to + 1;
        if (overrun) n_ov <= n_ov + 1;
        if (word_valid && !wv_q) n_rise <= n_rise + 1;
        wv_q <= word_valid;
        if (word_valid && word_ready) got.push_back(word_out);
    end
    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask
    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic send_byte(input logic [7:0] b, input bit stop_ok = 1'b1, input bit par_ok = 1'b1);
        rx = 1'b0;
        hold(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            hold(CPB);
        end
`ifdef UART_RX_PARITY_EN
        rx = (^b) ^ !par_ok;
        hold(CPB);
`endif
        rx = stop_ok;
        hold(CPB);
        rx = 1'b1;
        hold(CPB);
    endtask
    task automatic send_word(input logic [63:0] w);
        for (int k = 0; k < BPW; k++) send_byte(w[8*k +: 8]);
    endtask
    task automatic drain(input string tag);
        int t = 0;
        while (got.size() < exp_q.size() && t < 40 * CPB) begin
            @(posedge clk);
            t++;
        end
        #1;
        check({tag, "_count"}, 64'(got.size()), 64'(exp_q.size()));
        while (got.size() > 0 && exp_q.size() > 0) check(tag, got.pop_front(), exp_q.pop_front());
        got.delete();
        exp_q.delete();
    endtask
    task automatic rand_word(input string tag);
        logic [63:0] w;
        w = {$urandom, $urandom};
        send_word(w);
        exp_q.push_back(w);
        drain(tag);
    endtask
    initial begin
        logic [63:0] w, a;
        int base;
        repeat (3) @(posedge clk);
        #1;
        check("rst_word", word_out, 0);
        check("rst_valid", word_valid, 0);
        check("rst_flags", {frame_err, timeout_err, overrun}, 0);
        check("rst_busy", busy, 0);
        reset = 1'b0;
        hold(CPB);
        send_word(64'h3FE870B3B839FEE6);
        exp_q.push_back(64'h3FE870B3B839FEE6);
        drain("plan_word");
        check("plan_rise", n_rise, 1);
        check("plan_errs", n_fe + n_to + n_ov, 0);
        for (int i = 0; i < 4; i++) begin
            w = {$urandom, $urandom};
            send_word(w);
            exp_q.push_back(w);
        end
        drain("rand_word");
        check("rand_rise", n_rise, 5);
        word_ready = 1'b0;
        base = n_ov;
        a = 64'h3FF9FEE242998606;
        send_word(a);
        send_word({$urandom, $urandom});
        hold(2 * CPB);
        check("ovr_pulse", n_ov - base, 1);
        check("ovr_hold", word_out, a);
        check("ovr_valid", word_valid, 1);
        word_ready = 1'b1;
        hold(1);
        check("ovr_clear", word_valid, 0);
        exp_q.push_back(a);
        drain("ovr_word");
        base = n_fe;
        rx = 1'b0;
        hold(CPB * 3 / 10);
        rx = 1'b1;
        hold(2 * CPB);
        check("glitch_busy", busy, 0);
        check("glitch_fe", n_fe - base, 0);
        rand_word("glitch_word");
        base = n_fe;
        repeat (3) send_byte(8'($urandom));
        send_byte(8'($urandom), 1'b0);
        check("fe_pulse", n_fe - base, 1);
        check("fe_busy", busy, 0);
        rand_word("fe_word");
        base = n_to;
        repeat (5) send_byte(8'($urandom));
        check("to_busy_pre", busy, 1);
        hold((TOB + 1) * CPB);
        check("to_pulse", n_to - base, 1);
        check("to_busy", busy, 0);
        rand_word("to_word");
`ifdef UART_RX_PARITY_EN
        base = n_fe;
        send_byte(8'h01, 1'b1, 1'b0);
        check("par_bad", n_fe - base, 1);
        check("par_bad_busy", busy, 0);
        send_byte(8'h01);
        check("par_ok_busy", busy, 1);
        w = {$urandom, $urandom};
        w[7:0] = 8'h01;
        for (int k = 1; k < BPW; k++) send_byte(w[8*k +: 8]);
        exp_q.push_back(w);
        drain("par_word");
        check("par_fe_total", n_fe - base, 1);
`endif
        repeat (2) send_byte(8'($urandom));
        rx = 1'b0;
        hold(3 * CPB);
        reset = 1'b1;
        hold(1);
        check("mid_rst_word", word_out, 0);
        check("mid_rst_valid", word_valid, 0);
        check("mid_rst_flags", {frame_err, timeout_err, overrun}, 0);
        check("mid_rst_busy", busy, 0);
        reset = 1'b0;
        rx = 1'b1;
        hold(2 * CPB);
        rand_word("post_rst_word");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
